// File: rtl/imm_pkg.sv
// imm_pkg: shared widths, beat-kind encodings and FSM state type for the immediate narrowing encoder
package imm_pkg;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam logic [1:0] KIND_SINGLE = 2'b00;
    localparam logic [1:0] KIND_UPPER  = 2'b01;
    localparam logic [1:0] KIND_LOWER  = 2'b10;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_UPPER,
        ST_LOWER
    } state_t;
endpackage

// File: rtl/imm_narrow_encoder_if.sv
// imm_narrow_encoder_if: constant-in / immediate-beat-out valid-ready bundle
interface imm_narrow_encoder_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_value;
    logic              in_zext;
    logic              out_valid;
    logic              out_ready;
    logic [IMM_W-1:0]  out_imm;
    logic [1:0]        out_kind;
    logic              out_last;
    modport master (
        output in_valid, in_value, in_zext, out_ready,
        input  in_ready, out_valid, out_imm, out_kind, out_last
    );
    modport slave (
        input  in_valid, in_value, in_zext, out_ready,
        output in_ready, out_valid, out_imm, out_kind, out_last
    );
endinterface

// File: rtl/imm_fit_check.sv
// imm_fit_check: does a constant survive a round trip through one extended immediate field
module imm_fit_check #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [DATA_W-1:0] value,
    input  logic              zext,
    output logic              fits
);
    // sign mode needs the upper half plus the field's sign bit to be all-equal
    logic sign_fits;
    logic zext_fits;
    assign sign_fits = (&value[DATA_W-1:IMM_W-1]) | ~(|value[DATA_W-1:IMM_W-1]);
    assign zext_fits = ~(|value[DATA_W-1:IMM_W]);
    assign fits      = zext ? zext_fits : sign_fits;
endmodule

// File: rtl/imm_narrow_encoder.sv
// imm_narrow_encoder: splits a constant into SINGLE or UPPER+LOWER immediate beats.
// Build option IMM_SKIP_ZERO_LOW_EN: drop the LOWER beat when the low half is zero.
module imm_narrow_encoder #(
    parameter int DATA_W = imm_pkg::DATA_W,
    parameter int IMM_W  = imm_pkg::IMM_W
) (
    input logic                 clk,
    input logic                 reset,
    imm_narrow_encoder_if.slave bus
);
    import imm_pkg::*;

    if (DATA_W != 2 * IMM_W || $bits(bus.in_value) != DATA_W || $bits(bus.out_imm) != IMM_W) begin : g_width_check
        $error("imm_narrow_encoder: DATA_W must equal 2*IMM_W and match the interface");
    end

    state_t             state, state_n;
    logic [IMM_W-1:0]   imm_q, imm_n;
    logic [IMM_W-1:0]   lo_q, lo_n;
    logic [1:0]         kind_q, kind_n;
    logic               last_q, last_n;
    logic               fits;
    logic               out_valid;
    logic               accept;
    logic               fire;
    logic               upper_last;
    logic [IMM_W-1:0]   in_lo;
    logic [IMM_W-1:0]   in_hi;

    imm_fit_check #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_fit (
        .value (bus.in_value),
        .zext  (bus.in_zext),
        .fits  (fits)
    );

    assign in_lo     = bus.in_value[IMM_W-1:0];
    assign in_hi     = bus.in_value[DATA_W-1:IMM_W];
    assign out_valid = (state != ST_IDLE);
    assign fire      = out_valid && bus.out_ready;
    assign accept    = bus.in_valid && bus.in_ready;

`ifdef IMM_SKIP_ZERO_LOW_EN
    assign upper_last = ~(|in_lo);
`else
    assign upper_last = 1'b0;
`endif

    assign bus.in_ready  = !out_valid || (bus.out_ready && last_q);
    assign bus.out_valid = out_valid;
    assign bus.out_imm   = imm_q;
    assign bus.out_kind  = kind_q;
    assign bus.out_last  = last_q;

    // state and beat registers; reset discards any pending beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            imm_q  <= '0;
            lo_q   <= '0;
            kind_q <= KIND_SINGLE;
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            imm_q  <= imm_n;
            lo_q   <= lo_n;
            kind_q <= kind_n;
            last_q <= last_n;
        end
    end

    // next beat: new constant wins, else advance UPPER->LOWER or retire the final beat
    always_comb begin
        state_n = state;
        imm_n   = imm_q;
        lo_n    = lo_q;
        kind_n  = kind_q;
        last_n  = last_q;
        if (accept) begin
            state_n = fits ? ST_SINGLE : ST_UPPER;
            imm_n   = fits ? in_lo : in_hi;
            kind_n  = fits ? KIND_SINGLE : KIND_UPPER;
            last_n  = fits ? 1'b1 : upper_last;
            lo_n    = fits ? lo_q : in_lo;
        end else if (fire) begin
            state_n = last_q ? ST_IDLE : ST_LOWER;
            imm_n   = last_q ? imm_q : lo_q;
            kind_n  = last_q ? kind_q : KIND_LOWER;
            last_n  = 1'b1;
        end
    end
endmodule
